bcd_seven_segment_scan: RTL and testbench
=========================================

Name: bcd_seven_segment_scan

Overview:
Downstream consumer of the 14-bit binary-to-BCD converter. It takes the four BCD digits (thousands/hundreds/tens/ones) and time-multiplexes them onto a 4-digit common-anode seven-segment display with active-low anodes and cathodes. It provides a refresh prescaler, digit scan, per-frame input snapshot (tear-free), leading-zero blanking, an anti-ghosting blank interval and an invalid-digit indication.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
BLANK_CYCLES, 500, cycles at start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ones  input  4  BCD ones digit
tens  input  4  BCD tens digit
hundreds  input  4  BCD hundreds digit
thousands  input  4  BCD thousands digit
dp_in  input  4  decimal point per digit, active-high, bit0=ones
lzb_en  input  1  1 = blank leading zeros
an  output  4  anode enables, active-low, an[0]=ones ... an[3]=thousands
seg  output  7  cathodes, active-low, seg[0]=a ... seg[6]=g
dp  output  1  decimal point cathode, active-low
frame_tick  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: one clock, reset_n asynchronous active-low. Asserting reset_n=0 clears immediately: cnt=0, idx=0, snapshot digits=0, snapshot dp=0. Outputs go to an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0. Same behaviour applies mid-scan; no partial state survives.
- Prescaler: cnt counts 0..REFRESH_DIV-1, then wraps to 0.
- Slot advance: on the wrap edge, idx advances 0->1->2->3->0. idx 0=ones, 1=tens, 2=hundreds, 3=thousands.
- Snapshot: on the edge where idx wraps 3->0, {thousands,hundreds,tens,ones,dp_in,lzb_en} are registered into the snapshot. frame_tick=1 for exactly the following cycle.
- Input changes between snapshots are never displayed.
- After reset, the first frame (4*REFRESH_DIV cycles) displays snapshot=0.
- Outputs: an/seg/dp are registered. They are a function of (cnt, idx, snapshot) with exactly 1 cycle latency.
- Blank interval: while cnt < BLANK_CYCLES, an=1111, seg=1111111, dp=1.
- Active slot: otherwise, an = ~(1<<idx), and seg is driven from the selected snapshot digit.
- Segment encoding (active-low, bits g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Invalid digit (>9): shows dash, seg=0111111 (g only). An invalid digit counts as non-zero for blanking.
- Leading-zero blanking (snapshot lzb_en=1):
  - thousands blank if th==0.
  - hundreds blank if th==0 && hu==0.
  - tens blank if th==hu==te==0.
  - ones never blanked.
  - A blanked digit gives an=1111, seg=1111111, dp=1 for the whole slot.
- dp = ~snapshot_dp[idx] when the slot is active and not blanked; 1 otherwise.
- Width rules: cnt width = clog2(REFRESH_DIV). idx is 2 bits and wraps naturally.

Test Plan:
- Reset, REFRESH_DIV=4, BLANK_CYCLES=1: hold reset_n=0 -> an=1111, seg=1111111, dp=1, frame_tick=0. Release -> first frame shows ones slot seg=1000000 on an=1110.
- Apply 1234, lzb_en=0, dp_in=0100; wait past first frame -> frame_tick pulses once per 16 cycles. Per slot after 1 blank cycle:
  - an=1110 seg=0011001
  - an=1101 seg=0110000 dp=1
  - an=1011 seg=0100100 dp=0
  - an=0111 seg=1111001
- Apply 0007, lzb_en=1 -> thousands/hundreds/tens slots fully dark (an=1111). Ones slot an=1110 seg=1111000. With lzb_en=0 -> seg=1000000 on the three upper slots.
- Apply thousands=4'hA, others 0, lzb_en=1 -> thousands slot seg=0111111 (dash). Hundreds and tens are not blanked and show seg=1000000.
- Change inputs 9999->0000 mid-frame (idx=1) -> remaining slots of the frame still show 9 (0010000). 0 appears only after the next frame_tick.
- Assert reset_n low at idx=2, cnt=2, asynchronously between edges -> outputs dark immediately without a clock edge. After release, scan restarts at idx=0 with snapshot 0.

Source files
------------

// File: rtl/bcd_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seven_segment_scan
// Purpose  : Time-multiplexed driver for a 4-digit common-anode seven-segment
//            display fed by four BCD digits. Provides a refresh prescaler,
//            digit scan, per-frame (tear-free) input snapshot, leading-zero
//            blanking, an anti-ghosting blank interval at the start of each
//            digit slot, and a dash for invalid (>9) digits.
// Ports    : clk          - system clock, rising edge
//            reset_n      - asynchronous active-low reset
//            ones/tens/hundreds/thousands - BCD digits (4 bits each)
//            dp_in[3:0]   - decimal point per digit, active-high, bit0=ones
//            lzb_en       - 1 = blank leading zeros
//            an[3:0]      - anode enables, active-low, an[0]=ones
//            seg[6:0]     - cathodes, active-low, seg[0]=a .. seg[6]=g
//            dp           - decimal point cathode, active-low
//            frame_tick   - one-cycle pulse after a new snapshot is taken
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seven_segment_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_in,
  input  logic       lzb_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int                  c_cnt_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_blank    = c_cnt_w'(BLANK_CYCLES);
  localparam logic [3:0]          c_an_off   = 4'b1111;
  localparam logic [6:0]          c_seg_off  = 7'b1111111;
  localparam logic [6:0]          c_seg_dash = 7'b0111111;

  // Active-low segment pattern, bits g..a. Anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = c_seg_dash;
    endcase
    return pattern;
  endfunction

  // Scan state
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_idx;

  // Frame snapshot: only these values ever reach the display
  logic [3:0] r_snap_ones;
  logic [3:0] r_snap_tens;
  logic [3:0] r_snap_hund;
  logic [3:0] r_snap_thou;
  logic [3:0] r_snap_dp;
  logic       r_snap_lzb;

  // Next-output values computed from the current scan state
  logic       w_wrap;
  logic       w_frame_end;
  logic       w_in_blank;
  logic       w_lz_blank;
  logic [3:0] w_digit;
  logic [3:0] w_an_next;
  logic [6:0] w_seg_next;
  logic       w_dp_next;

  assign w_wrap      = (r_cnt == c_cnt_last);
  assign w_frame_end = w_wrap && (r_idx == 2'd3);
  assign w_in_blank  = (r_cnt < c_blank);

  always_comb begin
    w_digit    = r_snap_ones;
    w_lz_blank = 1'b0;
    w_an_next  = c_an_off;
    w_seg_next = c_seg_off;
    w_dp_next  = 1'b1;

    // Invalid digits are non-zero, so they stop the blanking chain too.
    case (r_idx)
      2'd0: begin
        w_digit    = r_snap_ones;
        w_lz_blank = 1'b0;
      end
      2'd1: begin
        w_digit    = r_snap_tens;
        w_lz_blank = r_snap_lzb && (r_snap_thou == 4'd0) &&
                     (r_snap_hund == 4'd0) && (r_snap_tens == 4'd0);
      end
      2'd2: begin
        w_digit    = r_snap_hund;
        w_lz_blank = r_snap_lzb && (r_snap_thou == 4'd0) &&
                     (r_snap_hund == 4'd0);
      end
      default: begin
        w_digit    = r_snap_thou;
        w_lz_blank = r_snap_lzb && (r_snap_thou == 4'd0);
      end
    endcase

    if (!w_in_blank && !w_lz_blank) begin
      w_an_next  = ~(4'b0001 << r_idx);
      w_seg_next = seg_decode(w_digit);
      w_dp_next  = ~r_snap_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_snap_ones <= 4'd0;
      r_snap_tens <= 4'd0;
      r_snap_hund <= 4'd0;
      r_snap_thou <= 4'd0;
      r_snap_dp   <= 4'd0;
      r_snap_lzb  <= 1'b0;
      an          <= c_an_off;
      seg         <= c_seg_off;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
      end

      // Capture a whole frame's worth of inputs at once so a digit change
      // mid-frame can never produce a mixed (torn) display.
      if (w_frame_end) begin
        r_snap_ones <= ones;
        r_snap_tens <= tens;
        r_snap_hund <= hundreds;
        r_snap_thou <= thousands;
        r_snap_dp   <= dp_in;
        r_snap_lzb  <= lzb_en;
      end
      frame_tick <= w_frame_end;

      an  <= w_an_next;
      seg <= w_seg_next;
      dp  <= w_dp_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seven_segment_scan
// Purpose  : Directed self-checking bench for bcd_seven_segment_scan with
//            REFRESH_DIV=4, BLANK_CYCLES=1 (16-cycle frames).
//            Expected outputs per slot are packed as {an, seg, dp}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seven_segment_scan;

  logic       clk;
  logic       reset_n;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic [3:0] thousands;
  logic [3:0] dp_in;
  logic       lzb_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  localparam logic [11:0] c_dark = 12'hFFF;

  // Slot patterns {an, seg, dp}, hand-derived
  localparam logic [11:0] c_o0 = {4'b1110, 7'b1000000, 1'b1};
  localparam logic [11:0] c_t0 = {4'b1101, 7'b1000000, 1'b1};
  localparam logic [11:0] c_h0 = {4'b1011, 7'b1000000, 1'b1};
  localparam logic [11:0] c_k0 = {4'b0111, 7'b1000000, 1'b1};
  localparam logic [47:0] c_zero = {c_k0, c_h0, c_t0, c_o0};

  localparam logic [47:0] c_1234 = {{4'b0111, 7'b1111001, 1'b1},
                                    {4'b1011, 7'b0100100, 1'b0},
                                    {4'b1101, 7'b0110000, 1'b1},
                                    {4'b1110, 7'b0011001, 1'b1}};

  localparam logic [11:0] c_o7 = {4'b1110, 7'b1111000, 1'b1};
  localparam logic [47:0] c_0007_lzb = {c_dark, c_dark, c_dark, c_o7};
  localparam logic [47:0] c_0007     = {c_k0, c_h0, c_t0, c_o7};

  localparam logic [47:0] c_a000_lzb = {{4'b0111, 7'b0111111, 1'b1}, c_h0, c_t0, c_o0};

  localparam logic [47:0] c_9999 = {{4'b0111, 7'b0010000, 1'b1},
                                    {4'b1011, 7'b0010000, 1'b1},
                                    {4'b1101, 7'b0010000, 1'b1},
                                    {4'b1110, 7'b0010000, 1'b1}};

  bcd_seven_segment_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .dp_in     (dp_in),
    .lzb_en    (lzb_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] val, input logic [3:0] dpv, input logic lzb);
    thousands = val[15:12];
    hundreds  = val[11:8];
    tens      = val[7:4];
    ones      = val[3:0];
    dp_in     = dpv;
    lzb_en    = lzb;
  endtask

  // Called at the negedge where a frame begins (frame_tick high, or just
  // after reset release). Negedge k shows the state of cycle k-1: slot
  // (k-1)/4, count (k-1)%4; count 0 is the blank cycle. frame_tick is
  // expected high again only at k=16. With mid_zero set, all digits are
  // driven to 0 at k=6 (tens slot) to show they are not picked up.
  task automatic check_frame(input string name, input logic [47:0] vs,
                             input int ncyc, input bit mid_zero);
    logic [11:0] exp;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      exp = (((k - 1) % 4) == 0) ? c_dark : vs[((k - 1) / 4) * 12 +: 12];
      chk($sformatf("%s k%0d out", name, k), {an, seg, dp}, exp);
      chk($sformatf("%s k%0d tick", name, k), {11'd0, frame_tick},
          {11'd0, (k == 16)});
      if (mid_zero && k == 6) set_in(16'h0000, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    set_in(16'h0000, 4'b0000, 1'b0);
    #1 reset_n = 1'b0;

    // Held in reset: dark, no tick
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset out", {an, seg, dp}, c_dark);
      chk("reset tick", {11'd0, frame_tick}, 12'd0);
    end

    // Release with 1234 on the inputs; first frame still shows zeros
    set_in(16'h1234, 4'b0100, 1'b0);
    reset_n = 1'b1;
    check_frame("first", c_zero, 16, 1'b0);

    set_in(16'h0007, 4'b0000, 1'b1);
    check_frame("f1234", c_1234, 16, 1'b0);

    set_in(16'h0007, 4'b0000, 1'b0);
    check_frame("f0007lzb", c_0007_lzb, 16, 1'b0);

    set_in(16'hA000, 4'b0000, 1'b1);
    check_frame("f0007", c_0007, 16, 1'b0);

    set_in(16'h9999, 4'b0000, 1'b0);
    check_frame("fA000lzb", c_a000_lzb, 16, 1'b0);

    // Inputs drop to 0000 during this frame; 9s must persist
    check_frame("f9999", c_9999, 16, 1'b1);

    // Zeros after the next tick; stop at idx=2, cnt=2 with nonzero inputs
    set_in(16'h5555, 4'b1111, 1'b0);
    check_frame("f0000", c_zero, 10, 1'b0);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("async out", {an, seg, dp}, c_dark);
    chk("async tick", {11'd0, frame_tick}, 12'd0);
    @(negedge clk);
    chk("async hold out", {an, seg, dp}, c_dark);
    reset_n = 1'b1;

    // Scan restarts at ones with a cleared snapshot (not 5555)
    check_frame("restart", c_zero, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
